// File: rtl/merge_output_writer.sv
// Output stage behind the merger tree root: buffers merged beats, packs them into
// memory write bursts from a programmable base address, and flushes on the all-zero terminator.
module merge_output_writer #(
    parameter int DATA_WIDTH = 128,
    parameter int ADDR_WIDTH = 32,
    parameter int BURST_LEN  = 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_start,
    input  logic [ADDR_WIDTH-1:0]   i_base_addr,
    input  logic [4*DATA_WIDTH-1:0] i_data,
    input  logic                    i_write,
    output logic                    o_ready,
    output logic                    o_mem_req_valid,
    output logic [ADDR_WIDTH-1:0]   o_mem_addr,
    output logic [4:0]              o_mem_len,
    input  logic                    i_mem_req_ready,
    output logic                    o_mem_wvalid,
    output logic [4*DATA_WIDTH-1:0] o_mem_wdata,
    output logic                    o_mem_wlast,
    input  logic                    i_mem_wready,
    output logic                    o_done,
    output logic [31:0]             o_lines_written
);

    localparam int BEAT_W     = 4 * DATA_WIDTH;
    localparam int BEAT_BYTES = BEAT_W / 8;
    localparam int PW         = $clog2(FIFO_DEPTH);
    localparam int CW         = PW + 1;

    localparam logic [CW-1:0]         C_BURST      = CW'(BURST_LEN);
    localparam logic [CW-1:0]         C_DEPTH      = CW'(FIFO_DEPTH);
    localparam logic [4:0]            L_BURST      = 5'(BURST_LEN);
    localparam logic [ADDR_WIDTH-1:0] A_BEAT_BYTES = ADDR_WIDTH'(BEAT_BYTES);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_COLLECT = 3'd1,
        S_ADDR    = 3'd2,
        S_DATA    = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [BEAT_W-1:0]     r_mem [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr;
    logic [PW-1:0]         r_rd_ptr;
    logic [CW-1:0]         r_count;
    logic                  r_term_seen;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [4:0]            r_len;
    logic [4:0]            r_beats_left;
    logic [31:0]           r_lines;

    logic       w_armed;
    logic       w_ready;
    logic       w_accept;
    logic       w_is_term;
    logic       w_enq;
    logic       w_wvalid;
    logic       w_deq;
    logic       w_req_hs;
    logic       w_last_hs;
    logic       w_start;
    logic       w_load_len;
    logic [4:0] w_len_next;

    // o_ready depends only on registers so the tree root never sees a loop through i_write.
    assign w_armed   = (r_state == S_COLLECT) || (r_state == S_ADDR) || (r_state == S_DATA);
    assign w_ready   = w_armed && !r_term_seen && (r_count < C_DEPTH);
    assign w_accept  = i_write && w_ready;
    assign w_is_term = w_accept && (i_data == '0);
    assign w_enq     = w_accept && (i_data != '0);
    assign w_wvalid  = (r_state == S_DATA) && (r_beats_left != 5'd0);
    assign w_deq     = w_wvalid && i_mem_wready;
    assign w_req_hs  = (r_state == S_ADDR) && i_mem_req_ready;
    assign w_last_hs = w_deq && (r_beats_left == 5'd1);
    assign w_start   = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; the burst length is fixed at the COLLECT decision.
    always_comb begin
        w_next_state = r_state;
        w_load_len   = 1'b0;
        w_len_next   = r_len;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next_state = S_COLLECT;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (r_count >= C_BURST) begin
                    w_next_state = S_ADDR;
                    w_load_len   = 1'b1;
                    w_len_next   = L_BURST;
                end else if (r_term_seen && (r_count != '0)) begin
                    w_next_state = S_ADDR;
                    w_load_len   = 1'b1;
                    w_len_next   = 5'(r_count);
                end else if (r_term_seen) begin
                    w_next_state = S_DONE;
                end else begin
                    w_next_state = S_COLLECT;
                end
            end
            S_ADDR: begin
                if (i_mem_req_ready) begin
                    w_next_state = S_DATA;
                end else begin
                    w_next_state = S_ADDR;
                end
            end
            S_DATA: begin
                if (w_last_hs) begin
                    w_next_state = S_COLLECT;
                end else begin
                    w_next_state = S_DATA;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    w_next_state = S_COLLECT;
                end else begin
                    w_next_state = S_DONE;
                end
            end
            default: begin
                w_next_state = S_IDLE;
            end
        endcase
    end

    // Beat storage; contents need no reset because reads are gated by the valid qualifiers.
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Stream bookkeeping: address pointer, burst length, remaining beats, line counter.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_term_seen  <= 1'b0;
            r_addr       <= '0;
            r_len        <= 5'd0;
            r_beats_left <= 5'd0;
            r_lines      <= 32'd0;
        end else begin
            if (w_start) begin
                r_addr      <= i_base_addr;
                r_term_seen <= 1'b0;
                r_lines     <= 32'd0;
            end else begin
                if (w_is_term) begin
                    r_term_seen <= 1'b1;
                end
                if (w_deq) begin
                    r_lines <= r_lines + 32'd1;
                end
                if (w_last_hs) begin
                    r_addr <= r_addr + (ADDR_WIDTH'(r_len) * A_BEAT_BYTES);
                end
            end
            if (w_load_len) begin
                r_len <= w_len_next;
            end
            if (w_req_hs) begin
                r_beats_left <= r_len;
            end else if (w_deq) begin
                r_beats_left <= r_beats_left - 5'd1;
            end
        end
    end

    assign o_ready         = w_ready;
    assign o_mem_req_valid = (r_state == S_ADDR);
    assign o_mem_addr      = (r_state == S_ADDR) ? r_addr : '0;
    assign o_mem_len       = (r_state == S_ADDR) ? r_len : 5'd0;
    assign o_mem_wvalid    = w_wvalid;
    assign o_mem_wdata     = w_wvalid ? r_mem[r_rd_ptr] : '0;
    assign o_mem_wlast     = w_wvalid && (r_beats_left == 5'd1);
    assign o_done          = (r_state == S_DONE);
    assign o_lines_written = r_lines;

endmodule
